dma_task_receiver: RTL and testbench

//  DMA-side end of the processor->DMA task interface. The processor programs a

---
 rtl/dma_pkg.sv | 33 +++
 rtl/dma_addr_counter.sv | 54 +++++
 rtl/dma_task_receiver.sv | 168 ++++++++++++++++
 tb/tb_dma_task_receiver.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
`default_nettype none
// =====================================================================
// dma_pkg : mode, register-address and FSM encodings for the DMA task
//           receiver.                                   Rev 1.0
// =====================================================================
package dma_pkg;

  typedef enum logic [1:0] {
    MODE_MEM_IO1 = 2'b00,
    MODE_IO2_MEM = 2'b01,
    MODE_MEM_MEM = 2'b10,
    MODE_ILLEGAL = 2'b11
  } mode_t;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DEST  = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_NXT  = 3'd5,
    ST_REL  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dma_addr_counter.sv
`default_nettype none
// =====================================================================
// dma_addr_counter : loadable incrementing src/dest pair plus a
//                    decrementing word count with zero/last flags. Rev 1.0
// =====================================================================
module dma_addr_counter #(
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_src,
  input  logic          load_dest,
  input  logic          load_count,
  input  logic [AW-1:0] src_in,
  input  logic [AW-1:0] dest_in,
  input  logic [CW-1:0] count_in,
  input  logic          step,
  output logic [AW-1:0] src,
  output logic [AW-1:0] dest,
  output logic [CW-1:0] count,
  output logic          zero,
  output logic          last
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src   <= '0;
      dest  <= '0;
      count <= '0;
    end else begin
      if (load_src)
        src <= src_in;
      else if (step)
        src <= src + AW'(1);

      if (load_dest)
        dest <= dest_in;
      else if (step)
        dest <= dest + AW'(1);

      if (load_count)
        count <= count_in;
      else if (step)
        count <= count - CW'(1);
    end
  end

  assign zero = (count == '0);
  // Seen while stepping the final word, so the FSM can release the bus.
  assign last = (count == CW'(1));

endmodule
`default_nettype wire

// File: rtl/dma_task_receiver.sv
`default_nettype none
// =====================================================================
// dma_task_receiver : processor-programmed DMA task engine moving one
//                     word per 4 clocks over the shared AB/DB bus. Rev 1.0
// =====================================================================
module dma_task_receiver
  import dma_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          wr,
  input  logic [1:0]    reg_addr,
  input  logic [DW-1:0] data_in,
  input  logic          HACK,
  input  logic [DW-1:0] DB_in,
  output logic          HREQ,
  output logic [AW-1:0] AB,
  output logic [DW-1:0] DB_out,
  output logic          read_memory,
  output logic          read_io,
  output logic          Enable_memory,
  output logic          Enable_IO1,
  output logic          Enable_IO2,
  output logic [CW-1:0] word_count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t        state, state_nxt;
  mode_t         mode;
  logic [DW-1:0] data_reg;
  logic          grant_lost;
  logic [AW-1:0] src, dest;
  logic          cnt_zero, cnt_last;
  logic          step;
  logic          reg_wr, ctrl_wr, start, start_bad, start_ok;

  assign reg_wr    = cs && wr && (state == ST_IDLE);
  assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
  assign start     = ctrl_wr && data_in[CTRL_START_BIT];
  assign start_bad = start && (data_in[1:0] == MODE_ILLEGAL);
  assign start_ok  = start && !start_bad;

  dma_addr_counter #(.AW(AW), .CW(CW)) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_src   (reg_wr && (reg_addr == REG_SRC)),
    .load_dest  (reg_wr && (reg_addr == REG_DEST)),
    .load_count (reg_wr && (reg_addr == REG_COUNT)),
    .src_in     (AW'(data_in)),
    .dest_in    (AW'(data_in)),
    .count_in   (CW'(data_in)),
    .step       (step),
    .src        (src),
    .dest       (dest),
    .count      (word_count),
    .zero       (cnt_zero),
    .last       (cnt_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      mode       <= MODE_MEM_IO1;
      data_reg   <= '0;
      err        <= 1'b0;
      grant_lost <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ctrl_wr)
        mode <= mode_t'(data_in[1:0]);
      if (state == ST_CAP)
        data_reg <= DB_in;
      if (start_bad)
        err <= 1'b1;
      else if (start_ok)
        err <= 1'b0;
      // Remember a grant drop mid-word so the word finishes, then re-request.
      if (state == ST_REQ)
        grant_lost <= 1'b0;
      else if (!HACK && (state == ST_RD || state == ST_CAP || state == ST_WR))
        grant_lost <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    HREQ          = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    AB            = '0;
    DB_out        = '0;
    read_memory   = 1'b0;
    read_io       = 1'b0;
    Enable_memory = 1'b0;
    Enable_IO1    = 1'b0;
    Enable_IO2    = 1'b0;
    step          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok)
          state_nxt = cnt_zero ? ST_REL : ST_REQ;
      end
      ST_REQ: begin
        HREQ = 1'b1;
        busy = 1'b1;
        if (HACK)
          state_nxt = ST_RD;
      end
      ST_RD: begin
        HREQ = 1'b1;
        busy = 1'b1;
        AB   = src;
        case (mode)
          MODE_IO2_MEM: begin
            Enable_IO2 = 1'b1;
            read_io    = 1'b1;
          end
          default: begin
            Enable_memory = 1'b1;
            read_memory   = 1'b1;
          end
        endcase
        state_nxt = ST_CAP;
      end
      ST_CAP: begin
        HREQ      = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_WR;
      end
      ST_WR: begin
        HREQ   = 1'b1;
        busy   = 1'b1;
        AB     = dest;
        DB_out = data_reg;
        if (mode == MODE_MEM_IO1)
          Enable_IO1 = 1'b1;
        else
          Enable_memory = 1'b1;
        state_nxt = ST_NXT;
      end
      ST_NXT: begin
        HREQ = 1'b1;
        busy = 1'b1;
        step = 1'b1;
        if (cnt_last)
          state_nxt = ST_REL;
        else if (grant_lost || !HACK)
          state_nxt = ST_REQ;
        else
          state_nxt = ST_RD;
      end
      ST_REL: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_task_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// tb_dma_task_receiver : randomized bench with a transaction-level
//                        model of expected bus reads/writes.   Rev 1.0
// =====================================================================
module tb_dma_task_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b0;
  logic       wr = 1'b0;
  logic [1:0] reg_addr = 2'd0;
  logic [7:0] data_in = 8'd0;
  logic       HACK = 1'b1;
  logic [7:0] DB_in = 8'd0;
  logic       HREQ, read_memory, read_io, Enable_memory, Enable_IO1, Enable_IO2;
  logic       busy, done, err;
  logic [7:0] AB, DB_out, word_count;

  dma_task_receiver #(.AW(8), .DW(8), .CW(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .reg_addr(reg_addr),
    .data_in(data_in), .HACK(HACK), .DB_in(DB_in), .HREQ(HREQ), .AB(AB),
    .DB_out(DB_out), .read_memory(read_memory), .read_io(read_io),
    .Enable_memory(Enable_memory), .Enable_IO1(Enable_IO1),
    .Enable_IO2(Enable_IO2), .word_count(word_count), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One expected bus beat; en is {IO2, IO1, memory}.
  typedef struct {
    bit       rd;
    bit [2:0] en;
    bit [7:0] addr;
    bit [7:0] data;
  } ev_t;

  ev_t        expq[$];
  bit   [7:0] mem [256];
  bit   [7:0] io2 [256];
  bit   [7:0] rd_log[$];
  bit   [7:0] m_src, m_dest, m_count;
  bit         m_busy;
  int         checks = 0, errors = 0;
  int         cyc = 0, wr_seen = 0, hreq_seen = 0, first_rd_cyc = -1;
  bit         hack_rand = 1'b0;
  bit   [7:0] pend;
  bit         pend_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hack_rand) HACK = ($urandom_range(0, 3) != 0);
  end

  // Compare process: every bus beat must match the next expected beat.
  always @(negedge clk) begin
    bit [2:0] en;
    ev_t      e;
    en = {Enable_IO2, Enable_IO1, Enable_memory};
    if (HREQ) hreq_seen++;
    if (pend_v) begin
      DB_in  = pend;
      pend_v = 1'b0;
    end else begin
      DB_in = 8'($urandom);
    end
    if (!reset && (en != 3'b000 || read_memory || read_io)) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bus: en=%b AB=%0d rm=%b rio=%b", en, AB, read_memory, read_io);
      end else begin
        e = expq.pop_front();
        chk("bus_enable", en, e.en);
        chk("bus_addr", AB, e.addr);
        chk("read_strobes", {read_memory, read_io}, e.rd ? (e.en[0] ? 2'b10 : 2'b01) : 2'b00);
        chk("hreq_during_bus", HREQ, 1);
        if (e.rd) begin
          pend   = e.en[0] ? mem[AB] : io2[AB];
          pend_v = 1'b1;
          rd_log.push_back(AB);
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end else begin
          chk("write_data", DB_out, e.data);
          wr_seen++;
        end
      end
    end
  end

  task automatic queue_task(input bit [1:0] md);
    bit [7:0] a;
    for (int i = 0; i < int'(m_count); i++) begin
      a = m_src + 8'(i);
      expq.push_back('{rd: 1'b1, en: (md == 2'b01) ? 3'b100 : 3'b001, addr: a, data: 8'd0});
      expq.push_back('{rd: 1'b0, en: (md == 2'b00) ? 3'b010 : 3'b001,
                       addr: m_dest + 8'(i), data: (md == 2'b01) ? io2[a] : mem[a]});
    end
    m_src   = m_src + m_count;
    m_dest  = m_dest + m_count;
    m_count = 8'd0;
  endtask

  task automatic wr_reg(input bit [1:0] a, input bit [7:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; reg_addr = a; data_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0;
    if (!m_busy) begin
      case (a)
        2'd0: m_src = d;
        2'd1: m_dest = d;
        2'd2: m_count = d;
        default: if (d[7] && d[1:0] != 2'b11 && m_count != 0) begin
          m_busy = 1'b1;
          queue_task(d[1:0]);
        end
      endcase
    end
  endtask

  task automatic start_task(input bit [7:0] s, input bit [7:0] d, input bit [7:0] n,
                            input bit [1:0] md, input bit wsrc);
    rd_log.delete();
    first_rd_cyc = -1;
    wr_seen = 0;
    if (wsrc) wr_reg(2'd0, s);
    wr_reg(2'd1, d);
    wr_reg(2'd2, n);
    wr_reg(2'd3, {6'b100000, md});
  endtask

  task automatic finish_task(input int bound, output int lat);
    bit got = 1'b0;
    int dc = 0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: done not seen within %0d cycles", bound);
    end else begin
      chk("queue_drained", expq.size(), 0);
      chk("word_count_end", word_count, 0);
      chk("busy_at_done", busy, 0);
      chk("hreq_at_done", HREQ, 0);
    end
    m_busy = 1'b0;
    expq.delete();
    lat = dc - first_rd_cyc;
    @(negedge clk);
    chk("done_single_cycle", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit [7:0] s, d, n;
    bit [1:0] md;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      io2[i] = 8'($urandom);
    end

    #12;
    chk("reset_outputs", {HREQ, AB, DB_out, read_memory, read_io, Enable_memory,
        Enable_IO1, Enable_IO2, word_count, busy, done, err}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // mem->IO1 with grant withheld for a few cycles
    HACK = 1'b0;
    start_task(8'd100, 8'd10, 8'd3, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    chk("hreq_waiting", HREQ, 1);
    chk("busy_waiting", busy, 1);
    chk("no_bus_before_grant", expq.size(), 6);
    HACK = 1'b1;
    finish_task(100, lat);
    chk("m2io1_latency", lat, 12);
    chk("m2io1_rd_addrs", {rd_log[0], rd_log[1], rd_log[2]}, {8'd100, 8'd101, 8'd102});

    start_task(8'd55, 8'd100, 8'd3, 2'b01, 1'b1);
    finish_task(100, lat);
    chk("io2mem_latency", lat, 12);
    chk("io2mem_rd_addrs", {rd_log[0], rd_log[1], rd_log[2]}, {8'd55, 8'd56, 8'd57});

    start_task(8'd70, 8'd100, 8'd5, 2'b10, 1'b1);
    finish_task(100, lat);
    chk("m2m_latency", lat, 20);
    chk("m2m_words", rd_log.size(), 5);

    // count = 0: done next cycle, no bus request
    hreq_seen = 0;
    wr_reg(2'd2, 8'd0);
    wr_reg(2'd3, 8'h80);
    chk("zero_count_done", done, 1);
    @(negedge clk);
    chk("zero_count_done_pulse", done, 0);
    chk("zero_count_no_hreq", hreq_seen, 0);

    // illegal mode: sticky err, no request
    wr_reg(2'd2, 8'd4);
    wr_reg(2'd3, 8'h83);
    chk("illegal_err", err, 1);
    repeat (5) @(negedge clk);
    chk("illegal_no_hreq", hreq_seen, 0);
    chk("illegal_err_sticky", err, 1);

    // address wrap; a valid start clears err
    start_task(8'd254, 8'd20, 8'd3, 2'b10, 1'b1);
    chk("err_cleared", err, 0);
    finish_task(100, lat);
    chk("wrap_rd_addrs", {rd_log[0], rd_log[1], rd_log[2]}, {8'd254, 8'd255, 8'd0});

    // grant dropped after word 2 of 5, with an ignored src write meanwhile
    start_task(8'd30, 8'd200, 8'd5, 2'b00, 1'b1);
    for (int i = 0; i < 100 && wr_seen < 2; i++) @(negedge clk);
    HACK = 1'b0;
    wr_reg(2'd0, 8'd9);
    repeat (2) @(negedge clk);
    chk("hack_low_hreq_held", HREQ, 1);
    chk("hack_low_paused", wr_seen, 2);
    HACK = 1'b1;
    finish_task(200, lat);
    chk("hack_drop_words", rd_log.size(), 5);
    chk("hack_drop_last_rd", rd_log[4], 8'd34);
    start_task(8'd0, 8'd90, 8'd2, 2'b10, 1'b0);
    finish_task(100, lat);
    chk("src_continues", rd_log[0], 8'd35);

    // reset in the middle of a task
    start_task(8'd5, 8'd6, 8'd6, 2'b10, 1'b1);
    for (int i = 0; i < 100 && wr_seen < 1; i++) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    expq.delete();
    #1;
    chk("midtask_reset_outputs", {HREQ, AB, DB_out, read_memory, read_io, Enable_memory,
        Enable_IO1, Enable_IO2, word_count, busy, done, err}, 64'd0);
    m_src = 8'd0; m_dest = 8'd0; m_count = 8'd0; m_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_task(8'd40, 8'd60, 8'd3, 2'b01, 1'b1);
    finish_task(100, lat);
    chk("post_reset_latency", lat, 12);

    // randomized tasks with a flaky grant
    hack_rand = 1'b1;
    for (int t = 0; t < 20; t++) begin
      s  = 8'($urandom);
      d  = 8'($urandom);
      n  = 8'($urandom_range(1, 6));
      md = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
      start_task(s, d, n, md, $urandom_range(0, 1) == 1);
      if (md == 2'b11) begin
        chk("rand_illegal_err", err, 1);
        chk("rand_illegal_idle", busy, 0);
      end else begin
        if ($urandom_range(0, 1) == 1) wr_reg(2'($urandom_range(0, 2)), 8'($urandom));
        finish_task(400, lat);
        chk("rand_words", rd_log.size(), n);
        chk("rand_err_clear", err, 0);
      end
    end
    hack_rand = 1'b0;
    HACK = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
